// File: rtl/hs32_prefetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hs32_prefetch_pkg : shared hs32 word constants, types and helpers     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package hs32_prefetch_pkg;

  localparam int HS32_XLEN      = 32;
  localparam int HS32_INST_STEP = 4;

  typedef logic [HS32_XLEN-1:0] hs32_word_t;

  typedef struct packed {
    hs32_word_t pc;
    hs32_word_t inst;
  } hs32_fetch_t;

  function automatic hs32_word_t hs32_next_pc(input hs32_word_t pc);
    return pc + hs32_word_t'(HS32_INST_STEP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs32_prefetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hs32_prefetch_if : memory request/response and decode hand-off bus    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface hs32_prefetch_if import hs32_prefetch_pkg::*; ();

  hs32_word_t addr;
  logic       stbm;
  logic       stlm;
  logic       ackm;
  hs32_word_t dtr;
  hs32_word_t instd;
  hs32_word_t pcd;
  logic       reqd;
  logic       rdyd;
  hs32_word_t newpc;
  logic       flush;

  // master is the prefetcher; slave is the memory/decode environment
  modport master (
    output addr, stbm, instd, pcd, reqd,
    input  stlm, ackm, dtr, rdyd, newpc, flush
  );

  modport slave (
    input  addr, stbm, instd, pcd, reqd,
    output stlm, ackm, dtr, rdyd, newpc, flush
  );

endinterface
`default_nettype wire

// File: rtl/hs32_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hs32_sync_fifo : first-word-fall-through FIFO with synchronous clear  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module hs32_sync_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 64
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  i_push,
  input  wire logic [WIDTH-1:0]      i_din,
  input  wire logic                  i_pop,
  input  wire logic                  i_clear,
  output logic      [WIDTH-1:0]      o_dout,
  output logic      [DEPTH_LOG2:0]   o_fill,
  output logic                       o_full
);

  localparam int                  CW      = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] c_DEPTH = CW'(1 << DEPTH_LOG2);

  logic [WIDTH-1:0]    r_mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + CW'(1);
      if (i_pop)  r_rptr <= r_rptr + CW'(1);
    end
  end

  // storage is deliberately left out of reset; the head is ignored while empty
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_din;
  end

  assign o_fill = r_wptr - r_rptr;
  assign o_full = (o_fill == c_DEPTH);
  assign o_dout = r_mem[r_rptr[DEPTH_LOG2-1:0]];

endmodule
`default_nettype wire

// File: rtl/hs32_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hs32_prefetch : instruction prefetcher with pipelined memory issue,   |
// | in-order response queue and flush with late-ack discard              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module hs32_prefetch import hs32_prefetch_pkg::*; #(
  parameter int         DEPTH_LOG2      = 2,
  parameter int         MAX_OUTSTANDING = 2,
  parameter hs32_word_t RESET_PC        = 32'h0000_0000
) (
  input wire logic         clk,
  input wire logic         reset,
  hs32_prefetch_if.master  bus
);

  localparam int CW      = DEPTH_LOG2 + 1;
  localparam int c_DEPTH = 1 << DEPTH_LOG2;

  hs32_word_t  r_ipc;
  hs32_word_t  r_rpc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic        r_armed;

  logic [CW-1:0] w_fill;
  logic          w_full;
  logic [CW:0]   w_inflight;
  logic          w_issue;
  logic          w_accept;
  logic          w_keep;
  logic          w_reqd;
  logic          w_pop;
  logic [CW-1:0] w_acc_inc;
  logic [CW-1:0] w_ack_dec;
  hs32_fetch_t   w_push_entry;
  hs32_fetch_t   w_head;

  // every in-flight request already owns a FIFO slot, so pushes can never overflow
  assign w_inflight = {1'b0, w_fill} + {1'b0, r_outst};
  assign w_issue    = r_armed && !bus.flush
                      && (w_inflight < (CW+1)'(c_DEPTH))
                      && (r_outst < CW'(MAX_OUTSTANDING));
  assign w_accept   = w_issue && !bus.stlm;
  assign w_keep     = bus.ackm && (r_discard == '0) && !bus.flush;
  assign w_reqd     = (w_fill != '0);
  assign w_pop      = w_reqd && bus.rdyd && !bus.flush;
  assign w_acc_inc  = CW'(w_accept);
  assign w_ack_dec  = CW'(bus.ackm);

  assign w_push_entry = '{pc: r_rpc, inst: bus.dtr};

  hs32_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (2 * HS32_XLEN)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_keep),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .i_clear (bus.flush),
    .o_dout  (w_head),
    .o_fill  (w_fill),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed   <= 1'b0;
      r_ipc     <= RESET_PC;
      r_rpc     <= RESET_PC;
      r_outst   <= '0;
      r_discard <= '0;
    end else begin
      r_armed <= 1'b1;
      if (bus.flush) begin
        // an ack arriving with the flush is consumed here, not discarded later
        r_ipc     <= bus.newpc;
        r_rpc     <= bus.newpc;
        r_outst   <= r_outst - w_ack_dec;
        r_discard <= r_outst - w_ack_dec;
      end else begin
        if (w_accept) r_ipc <= hs32_next_pc(r_ipc);
        if (w_keep)   r_rpc <= hs32_next_pc(r_rpc);
        r_outst <= r_outst + w_acc_inc - w_ack_dec;
        if (bus.ackm && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.ackm && (r_discard == '0) && (r_outst == '0)));
      assert (!(w_keep && w_full));
    end
  end

  assign bus.addr  = r_ipc;
  assign bus.stbm  = w_issue;
  assign bus.reqd  = w_reqd;
  assign bus.instd = w_head.inst;
  assign bus.pcd   = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_hs32_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hs32_prefetch : directed bench with an addr-echo memory responder  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_hs32_prefetch;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   cyc;
  int   lat;
  logic [31:0] pa[$];
  int          pd[$];

  hs32_prefetch_if bus ();

  hs32_prefetch #(
    .DEPTH_LOG2      (2),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  // memory echoes the request address as data, lat cycles after acceptance
  task automatic adv();
    if (!reset && bus.stbm && !bus.stlm) begin
      pa.push_back(bus.addr);
      pd.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.ackm = 1'b0;
    bus.dtr  = '0;
    if (!reset && pa.size() != 0 && pd[0] <= cyc) begin
      bus.ackm = 1'b1;
      bus.dtr  = pa.pop_front();
      pd.delete(0);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; lat = 1;
    reset = 1'b1;
    bus.stlm = 1'b0; bus.ackm = 1'b0; bus.dtr = '0;
    bus.rdyd = 1'b0; bus.newpc = '0; bus.flush = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    to_sample();
    chk("rst_stbm", bus.stbm, 0);
    chk("rst_reqd", bus.reqd, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    to_sample(); chk("release_stbm", bus.stbm, 0); adv();

    // fill with decode stalled
    to_sample(); chk("c0_stbm", bus.stbm, 1); chk("c0_addr", bus.addr, 32'h0); adv();
    to_sample(); chk("c1_reqd", bus.reqd, 0); adv();
    to_sample(); chk("c2_reqd", bus.reqd, 1); chk("c2_pcd", bus.pcd, 32'h0);
    chk("c2_instd", bus.instd, 32'h0); chk("c2_addr", bus.addr, 32'h8); adv();
    to_sample(); chk("c3_addr", bus.addr, 32'hC); adv();
    to_sample(); chk("c4_stbm", bus.stbm, 0); adv();
    to_sample(); chk("c5_full_stbm", bus.stbm, 0); chk("c5_pcd", bus.pcd, 32'h0); adv();

    // drain; stall rule still counts the entry popped this cycle
    bus.rdyd = 1'b1;
    to_sample(); chk("c6_pop_stbm", bus.stbm, 0); chk("c6_pcd", bus.pcd, 32'h0); adv();
    bus.stlm = 1'b1;
    to_sample(); chk("c7_pcd", bus.pcd, 32'h4); chk("c7_instd", bus.instd, 32'h4);
    chk("c7_stbm", bus.stbm, 1); chk("c7_addr", bus.addr, 32'h10); adv();
    to_sample(); chk("c8_pcd", bus.pcd, 32'h8); chk("c8_addr", bus.addr, 32'h10); adv();
    bus.rdyd = 1'b0;
    to_sample(); chk("c9_addr", bus.addr, 32'h10); chk("c9_stbm", bus.stbm, 1); adv();
    bus.stlm = 1'b0;
    to_sample(); chk("c10_addr", bus.addr, 32'h10); chk("c10_stbm", bus.stbm, 1); adv();
    lat = 3;
    to_sample(); chk("c11_addr", bus.addr, 32'h14); chk("c11_pcd", bus.pcd, 32'hC); adv();
    to_sample(); chk("c12_addr", bus.addr, 32'h18); chk("c12_stbm", bus.stbm, 1); adv();

    // flush with two requests in flight
    bus.flush = 1'b1; bus.newpc = 32'h100;
    to_sample(); chk("c13_flush_stbm", bus.stbm, 0); adv();
    bus.flush = 1'b0;
    to_sample(); chk("c14_reqd", bus.reqd, 0); chk("c14_stbm", bus.stbm, 0); adv();
    lat = 1;
    to_sample(); chk("c15_stbm", bus.stbm, 1); chk("c15_addr", bus.addr, 32'h100);
    chk("c15_reqd", bus.reqd, 0); adv();
    to_sample(); chk("c16_reqd", bus.reqd, 0); chk("c16_addr", bus.addr, 32'h104); adv();
    lat = 2;
    to_sample(); chk("c17_reqd", bus.reqd, 1); chk("c17_pcd", bus.pcd, 32'h100);
    chk("c17_instd", bus.instd, 32'h100); chk("c17_addr", bus.addr, 32'h108); adv();
    to_sample(); chk("c18_addr", bus.addr, 32'h10C); chk("c18_stbm", bus.stbm, 1); adv();

    // flush coinciding with ack and decode accept
    bus.flush = 1'b1; bus.rdyd = 1'b1; bus.newpc = 32'h200;
    to_sample(); chk("c19_stbm", bus.stbm, 0); chk("c19_reqd", bus.reqd, 1); adv();
    bus.flush = 1'b0; lat = 1;
    to_sample(); chk("c20_reqd", bus.reqd, 0); chk("c20_stbm", bus.stbm, 1);
    chk("c20_addr", bus.addr, 32'h200); adv();
    to_sample(); chk("c21_reqd", bus.reqd, 0); adv();

    // streaming at one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      if (i == 3) lat = 3;
      to_sample();
      chk("stream_reqd", bus.reqd, 1);
      chk("stream_pcd", bus.pcd, 32'h200 + 32'(4 * i));
      chk("stream_stbm", bus.stbm, 1);
      adv();
    end

    // reset mid-burst with two outstanding
    bus.rdyd = 1'b0;
    to_sample(); chk("c26_addr", bus.addr, 32'h218); chk("c26_pcd", bus.pcd, 32'h210); adv();
    to_sample(); chk("c27_reqd", bus.reqd, 1); chk("c27_stbm", bus.stbm, 0);
    reset = 1'b1;
    pa.delete(); pd.delete();
    lat = 1;
    #1;
    chk("async_reqd", bus.reqd, 0);
    chk("async_stbm", bus.stbm, 0);
    adv();
    reset = 1'b0;
    to_sample(); chk("r0_stbm", bus.stbm, 0); chk("r0_reqd", bus.reqd, 0); adv();
    to_sample(); chk("r1_stbm", bus.stbm, 1); chk("r1_addr", bus.addr, 32'h0);
    chk("r1_reqd", bus.reqd, 0); adv();
    to_sample(); chk("r2_reqd", bus.reqd, 0); chk("r2_addr", bus.addr, 32'h4); adv();
    to_sample(); chk("r3_reqd", bus.reqd, 1); chk("r3_pcd", bus.pcd, 32'h0);
    chk("r3_instd", bus.instd, 32'h0); chk("r3_stbm", bus.stbm, 1); adv();

    // flush while a strobe would otherwise be raised
    bus.flush = 1'b1; bus.newpc = 32'h300;
    to_sample(); chk("r4_flush_stbm", bus.stbm, 0); adv();
    bus.flush = 1'b0;
    to_sample(); chk("r5_reqd", bus.reqd, 0); chk("r5_stbm", bus.stbm, 1);
    chk("r5_addr", bus.addr, 32'h300); adv();
    to_sample(); adv();
    to_sample(); chk("r7_reqd", bus.reqd, 1); chk("r7_pcd", bus.pcd, 32'h300); adv();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hs32_prefetch.md
HS32_PREFETCH -- requirements
Module: hs32_prefetch

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2, meaning FIFO depth = 2^DEPTH_LOG2 words (legal range 1..4).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum accepted-but-unacknowledged memory requests (legal range 1..2^DEPTH_LOG2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port addr, output, 32, the request address, valid while stbm=1.
REQ-007 SHALL have port stbm, output, 1, the request strobe; one request per high cycle.
REQ-008 SHALL have port stlm, input, 1, same-cycle rejection of the request strobed in that cycle.
REQ-009 SHALL have port ackm, input, 1, response valid; responses return in request order.
REQ-010 SHALL have port dtr, input, 32, response data, valid while ackm=1.
REQ-011 SHALL have port instd, output, 32, the instruction at the FIFO head.
REQ-012 SHALL have port pcd, output, 32, the address of instd.
REQ-013 SHALL have port reqd, output, 1, meaning instd/pcd are valid.
REQ-014 SHALL have port rdyd, input, 1, decode accept; a transfer occurs when reqd and rdyd are both high.
REQ-015 SHALL have port newpc, input, 32, the restart address used on flush.
REQ-016 SHALL have port flush, input, 1, a synchronous pipeline flush.

Function
REQ-017 SHALL hold issue pointer ipc (drives addr) and response pointer rpc; both SHALL be 32-bit and wrap modulo 2^32 in +4 steps.
REQ-018 SHALL assert stbm in a cycle iff no flush is present and fill + outstanding < 2^DEPTH_LOG2 and outstanding < MAX_OUTSTANDING, where fill counts entries including one popped in the same cycle.
REQ-019 SHALL treat stbm && !stlm as accepted: ipc += 4 and outstanding += 1; on stbm && stlm, ipc SHALL be held and the request re-strobed next eligible cycle.
REQ-020 SHALL, on ackm with discard == 0, write {rpc, dtr} at the write pointer, advance the write pointer, set rpc += 4 and decrement outstanding.
REQ-021 SHALL handle simultaneous accept and ack with a net outstanding change of 0.
REQ-022 SHALL present the FIFO head first-word-fall-through: reqd = fill != 0, and ackm at cycle N SHALL make the entry visible at N+1.
REQ-023 SHALL pop the head on reqd && rdyd; push and pop in the same cycle SHALL leave fill unchanged.
REQ-024 SHALL, on flush, empty the FIFO, set ipc = rpc = newpc, deassert stbm that cycle, and set discard = outstanding - (ackm ? 1 : 0), with outstanding reduced to match.
REQ-025 SHALL, while discard > 0, drop each ackm and decrement discard and outstanding; issuing MAY continue during this time under REQ-018.
REQ-026 SHALL give flush priority over pop, push and issue in the same cycle.
REQ-027 SHALL use pointers and counters DEPTH_LOG2+1 bits wide, with full = (fill == 2^DEPTH_LOG2).
REQ-028 SHALL never overflow the FIFO; an ack with discard == 0 and outstanding == 0 is illegal and SHALL be a simulation assertion.

Reset
REQ-029 SHALL, on reset, asynchronously clear FIFO pointers, outstanding and discard.
REQ-030 SHALL, on reset, asynchronously force stbm = 0 and reqd = 0.
REQ-031 SHALL, on reset, asynchronously set ipc = rpc = RESET_PC.
REQ-032 SHALL NOT reset FIFO data storage; instd and pcd are don't-care while reqd = 0.
REQ-033 SHALL allow the first stbm no earlier than the first rising edge after reset deasserts.

Structure
REQ-034 SHALL place the shared hs32 package constants HS32_XLEN = 32 and HS32_INST_STEP = 4 in the package; DEPTH_LOG2 and MAX_OUTSTANDING remain module parameters.
REQ-035 SHALL instantiate one sub-module, hs32_sync_fifo: a parametrised 64-bit-wide, 2^DEPTH_LOG2-deep FWFT FIFO with push, pop, clear, fill and full.
REQ-036 SHALL keep all issue, outstanding and discard logic in hs32_prefetch.

Verification
REQ-037 SHALL cover reset release with a memory returning addr as data after 1 cycle: pcd/instd = 0/0, 4/4, 8/8 in order, and stbm SHALL stop when 4 entries are queued with rdyd = 0.
REQ-038 SHALL cover stlm = 1 for 3 strobes at addr 0x10: addr SHALL hold 0x10, and after stlm drops exactly one accept SHALL occur at 0x10 and the next strobe SHALL be at 0x14.
REQ-039 SHALL cover flush with newpc = 0x100 while 2 requests are outstanding: both late acks SHALL be dropped, and the first reqd SHALL show pcd = 0x100.
REQ-040 SHALL cover flush coinciding with ackm and rdyd: nothing is pushed or popped, discard = outstanding - 1, and reqd = 0 the next cycle.
REQ-041 SHALL cover continuous rdyd = 1 with single-cycle ack latency and MAX_OUTSTANDING = 2: sustained throughput of one instruction per cycle after the 2-cycle fill.
REQ-042 SHALL cover reset asserted mid-burst with 2 outstanding: stbm and reqd SHALL drop immediately, and after release the fetch SHALL restart at RESET_PC with no stale entries.
